pe_row_skew_buffer: RTL and testbench

//   Diagonal (triangular) skew buffer that sits directly upstream of the PE
//   row inputs of the systolic mesh. One unskewed beat of ROWS row operands
//   ('a' values) enters per cycle. Lane i leaves i+1 cycles later, so row i
//   of the mesh sees its operand one cycle after row i-1. Column control
//   (id/last) travels with lane 0. A done pulse fires when the skewed tail of
//   the last beat leaves lane ROWS-1.

---
 rtl/pe_row_skew_buffer_if.sv | 32 +++
 rtl/pe_row_skew_buffer.sv | 113 +++++++++++
 tb/tb_pe_row_skew_buffer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_row_skew_buffer_if.sv
// Bus bundle for the PE row skew buffer: unskewed beats in, skewed lanes out.
// Parameters must match the pe_row_skew_buffer instance that uses the slave side.
interface pe_row_skew_buffer_if #(
  parameter int ROWS = 4,
  parameter int A_W  = 8,
  parameter int ID_W = 3
);
  // Handshake: in_valid is a pure qualifier with no ready. A beat is taken on
  // every rising edge where in_valid=1, and out_valid[i] is a one-cycle strobe
  // that the mesh must consume immediately (no backpressure anywhere).
  logic                 in_valid;
  logic [ROWS*A_W-1:0]  in_data;
  logic [ID_W-1:0]      in_id;
  logic                 in_last;

  logic [ROWS-1:0]      out_valid;
  logic [ROWS*A_W-1:0]  out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_last;
  logic                 done;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_id, in_last,
    input  out_valid, out_data, out_id, out_last, done, busy
  );

  modport slave (
    input  in_valid, in_data, in_id, in_last,
    output out_valid, out_data, out_id, out_last, done, busy
  );
endinterface

// File: rtl/pe_row_skew_buffer.sv
// Triangular skew buffer ahead of the PE row inputs: lane i is delayed i+1
// cycles so row i of the mesh sees its operand one cycle after row i-1.
module pe_row_skew_buffer #(
  parameter int ROWS = 4,
  parameter int A_W  = 8,
  parameter int ID_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pe_row_skew_buffer_if.slave    bus
);

  logic [A_W-1:0] lane_data  [ROWS];
  logic           lane_valid [ROWS];
  logic           lane_busy  [ROWS];
  logic           last_head;
  logic           last_tail;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_d;

  for (genvar l = 0; l < ROWS; l++) begin : g_lane
    localparam int D = l + 1;

    logic [D-1:0]          vld_q;
    logic [D-1:0]          vld_d;
    logic [D-1:0][A_W-1:0] dat_q;
    logic [D-1:0][A_W-1:0] dat_d;

    // Data registers only load behind a valid stage; bubbles leave them still.
    always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      vld_d[0] = bus.in_valid;
      dat_d[0] = bus.in_valid ? bus.in_data[l*A_W +: A_W] : dat_q[0];
      for (int s = 1; s < D; s++) begin
        vld_d[s] = vld_q[s-1];
        dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign lane_valid[l] = vld_q[D-1];
    assign lane_data[l]  = dat_q[D-1];
    assign lane_busy[l]  = |vld_q;

    // The last flag is only observed on lane 0 and the tail lane.
    if (l == 0 || l == ROWS - 1) begin : g_last
      logic [D-1:0] lst_q;
      logic [D-1:0] lst_d;

      always_comb begin
        lst_d    = lst_q;
        lst_d[0] = bus.in_valid & bus.in_last;
        for (int s = 1; s < D; s++) begin
          lst_d[s] = lst_q[s-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lst_q <= '0;
        end else begin
          lst_q <= lst_d;
        end
      end

      if (l == 0) begin : g_head
        assign last_head = lst_q[D-1];
      end
      if (l == ROWS - 1) begin : g_tail
        assign last_tail = lst_q[D-1] & vld_q[D-1];
      end
    end
  end

  // The id rides with lane 0, which has a single stage.
  always_comb begin
    id_d = bus.in_valid ? bus.in_id : id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    bus.busy      = 1'b0;
    for (int l = 0; l < ROWS; l++) begin
      bus.out_valid[l]            = lane_valid[l];
      bus.out_data[l*A_W +: A_W]  = lane_data[l];
      bus.busy                    = bus.busy | lane_busy[l];
    end
  end

  assign bus.out_id   = id_q;
  assign bus.out_last = last_head;
  assign bus.done     = last_tail;

endmodule

// File: tb/tb_pe_row_skew_buffer.sv
// Directed table-driven bench for pe_row_skew_buffer (ROWS=4, A_W=8, ID_W=3).
module tb_pe_row_skew_buffer;
  localparam int ROWS = 4;
  localparam int A_W  = 8;
  localparam int ID_W = 3;
  localparam int DW   = ROWS * A_W;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pe_row_skew_buffer_if #(.ROWS(ROWS), .A_W(A_W), .ID_W(ID_W)) bus ();

  pe_row_skew_buffer #(.ROWS(ROWS), .A_W(A_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            vin;
    logic [DW-1:0]   din;
    logic [ID_W-1:0] idin;
    logic            lin;
    logic [ROWS-1:0] ev;
    logic [DW-1:0]   ed;
    logic [ID_W-1:0] eid;
    logic            el;
    logic            edone;
    logic            ebusy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vin, input logic [DW-1:0] din, input int idin,
                     input logic lin, input logic [ROWS-1:0] ev,
                     input logic [DW-1:0] ed, input int eid, input logic el,
                     input logic edone, input logic ebusy);
    vec_t v;
    v.vin = vin; v.din = din; v.idin = idin[ID_W-1:0]; v.lin = lin;
    v.ev = ev; v.ed = ed; v.eid = eid[ID_W-1:0]; v.el = el;
    v.edone = edone; v.ebusy = ebusy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [ID_W-1:0] id, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_id    = id;
    bus.in_last  = l;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, DW'(bus.out_valid), '0);
    chk({tag, " out_data"},  bus.out_data, '0);
    chk({tag, " out_id"},    DW'(bus.out_id), '0);
    chk({tag, " out_last"},  DW'(bus.out_last), '0);
    chk({tag, " done"},      DW'(bus.done), '0);
    chk({tag, " busy"},      DW'(bus.busy), '0);
  endtask

  task automatic run_table();
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      chk($sformatf("row%0d out_valid", r), DW'(bus.out_valid), DW'(tbl[r].ev));
      for (int i = 0; i < ROWS; i++) begin
        if (tbl[r].ev[i])
          chk($sformatf("row%0d lane%0d data", r, i),
              DW'(bus.out_data[i*A_W +: A_W]), DW'(tbl[r].ed[i*A_W +: A_W]));
      end
      if (tbl[r].ev[0])
        chk($sformatf("row%0d out_id", r), DW'(bus.out_id), DW'(tbl[r].eid));
      chk($sformatf("row%0d out_last", r), DW'(bus.out_last), DW'(tbl[r].el));
      chk($sformatf("row%0d done", r), DW'(bus.done), DW'(tbl[r].edone));
      chk($sformatf("row%0d busy", r), DW'(bus.busy), DW'(tbl[r].ebusy));
      drive(tbl[r].vin, tbl[r].din, tbl[r].idin, tbl[r].lin);
    end
  endtask

  initial begin
    logic [DW-1:0]   din;
    logic [DW-1:0]   ed;
    logic [ROWS-1:0] ev;
    logic            pat [5];
    int              eid;
    logic            el;
    logic            eb;

    n_tests = 0;
    n_fail  = 0;

    // single beat, id=5, last=1
    add(1, 32'h44332211, 5, 1, 4'b0000, '0, 0, 0, 0, 0);
    add(0, '0, 0, 0, 4'b0001, 32'h00000011, 5, 1, 0, 1);
    add(0, '0, 0, 0, 4'b0010, 32'h00002200, 0, 0, 0, 1);
    add(0, '0, 0, 0, 4'b0100, 32'h00330000, 0, 0, 0, 1);
    add(0, '0, 0, 0, 4'b1000, 32'h44000000, 0, 0, 1, 1);
    add(0, '0, 0, 0, 4'b0000, '0, 0, 0, 0, 0);

    // stream of 8 beats, lane i of beat k = 8*k+i, last on beat 7
    for (int c = 0; c <= 12; c++) begin
      din = '0; ed = '0; ev = '0; eid = 0; el = 1'b0;
      if (c < 8)
        for (int i = 0; i < ROWS; i++) din[i*A_W +: A_W] = A_W'(8*c + i);
      for (int i = 0; i < ROWS; i++) begin
        int k;
        k = c - i - 1;
        if (k >= 0 && k < 8) begin
          ev[i] = 1'b1;
          ed[i*A_W +: A_W] = A_W'(8*k + i);
        end
      end
      if (ev[0]) begin
        eid = c - 1;
        el  = (c - 1 == 7);
      end
      add(c < 8, din, c, c == 7, ev, ed, eid, el, c == 11, c >= 1 && c <= 11);
    end

    // bubbles: valid pattern 1,0,1,1,0
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c <= 9; c++) begin
      din = '0; ed = '0; ev = '0; eid = 0; eb = 1'b0;
      if (c < 5 && pat[c])
        for (int i = 0; i < ROWS; i++) din[i*A_W +: A_W] = A_W'(16*(c + 1) + i);
      for (int i = 0; i < ROWS; i++) begin
        int k;
        k = c - i - 1;
        if (k >= 0 && k < 5 && pat[k]) begin
          ev[i] = 1'b1;
          ed[i*A_W +: A_W] = A_W'(16*(k + 1) + i);
          if (i == 0) eid = k;
        end
      end
      for (int k = 0; k < 5; k++)
        if (pat[k] && c >= k + 1 && c <= k + ROWS) eb = 1'b1;
      add(c < 5 && pat[c], din, c, 0, ev, ed, eid, 0, 0, eb);
    end

    // tile boundary, done alongside a new beat, back-to-back last beats
    add(1, 32'h44332211, 1, 1, 4'b0000, '0, 0, 0, 0, 0);
    add(1, 32'h88776655, 2, 0, 4'b0001, 32'h00000011, 1, 1, 0, 1);
    add(0, '0, 0, 0, 4'b0011, 32'h00002255, 2, 0, 0, 1);
    add(0, '0, 0, 0, 4'b0110, 32'h00336600, 0, 0, 0, 1);
    add(1, 32'hDDCCBBAA, 3, 1, 4'b1100, 32'h44770000, 0, 0, 1, 1);
    add(1, 32'h04030201, 4, 1, 4'b1001, 32'h880000AA, 3, 1, 0, 1);
    add(0, '0, 0, 0, 4'b0011, 32'h0000BB01, 4, 1, 0, 1);
    add(0, '0, 0, 0, 4'b0110, 32'h00CC0200, 0, 0, 0, 1);
    add(0, '0, 0, 0, 4'b1100, 32'hDD030000, 0, 0, 1, 1);
    add(0, '0, 0, 0, 4'b1000, 32'h04000000, 0, 0, 1, 1);
    add(0, '0, 0, 0, 4'b0000, '0, 0, 0, 0, 0);

    // reset held with a beat presented
    rst_n = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 3'd7, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset hold");
    end
    drive(1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("post reset idle");
    end

    run_table();

    // reset mid-tile: drop in-flight beats, no done afterwards
    @(negedge clk);
    drive(1'b1, 32'hA1B2C3D4, 3'd6, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    chk("midreset lane0 valid", DW'(bus.out_valid), DW'(4'b0001));
    @(negedge clk);
    chk("midreset lane1 valid", DW'(bus.out_valid), DW'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("after midreset done", DW'(bus.done), '0);
      chk("after midreset valid", DW'(bus.out_valid), '0);
      chk("after midreset busy", DW'(bus.busy), '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
